// File: rtl/ldl_piso_shifter.sv
// Parallel-in/serial-out shifter: loads a LEVEL-sub-word word and emits one
// WIDTH-bit sub-word per output handshake, least-significant sub-word first.
module ldl_piso_shifter #(
    parameter int WIDTH = 8,
    parameter int LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LEVEL*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int BW = LEVEL * WIDTH;
    localparam int CW = $clog2(LEVEL + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(LEVEL);

    logic [BW-1:0] buff_q, buff_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          in_fire_s;
    logic          out_fire_s;

    // Accepting on the last sub-word's handshake lets words stream without a bubble.
    assign out_valid  = (cnt_q != CNT_ZERO);
    assign busy       = out_valid;
    assign out_data   = buff_q[WIDTH-1:0];
    assign out_last   = (cnt_q == CNT_ONE);
    assign in_ready   = (cnt_q == CNT_ZERO) | ((cnt_q == CNT_ONE) & out_ready);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next state: a load wins over a shift in the same cycle.
    always_comb begin
        buff_d = buff_q;
        cnt_d  = cnt_q;
        if (in_fire_s) begin
            buff_d = in_data;
            cnt_d  = CNT_FULL;
        end else if (out_fire_s) begin
            buff_d = buff_q >> WIDTH;
            cnt_d  = cnt_q - CNT_ONE;
        end else begin
            buff_d = buff_q;
            cnt_d  = cnt_q;
        end
    end

    // State registers with synchronous reset that discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            buff_q <= '0;
            cnt_q  <= CNT_ZERO;
        end else begin
            buff_q <= buff_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ldl_piso_shifter.sv
// Bench for ldl_piso_shifter: directed vector table plus scoreboard-checked
// sequences on a LEVEL=4 instance and a randomised LEVEL=1 instance.
module tb_ldl_piso_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LEVEL=4, WIDTH=8 instance
    logic        rst4 = 1'b1, iv4 = 1'b0, ir4, ov4, or4 = 1'b0, ol4, busy4;
    logic [31:0] id4 = 32'h0;
    logic [7:0]  od4;

    // LEVEL=1, WIDTH=8 instance
    logic        rst1 = 1'b1, iv1 = 1'b0, ir1, ov1, or1 = 1'b0, ol1, busy1;
    logic [7:0]  id1 = 8'h0;
    logic [7:0]  od1;

    ldl_piso_shifter #(.WIDTH(8), .LEVEL(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_last(ol4), .busy(busy4)
    );

    ldl_piso_shifter #(.WIDTH(8), .LEVEL(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1), .busy(busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        r;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        chk;
        logic        ev;
        logic        er;
        logic [7:0]  ed;
        logic        el;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    vec_t       tbl[$];
    item_t      q4[$];
    logic [7:0] q1[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic chk, input logic ev,
                                input logic er, input logic [7:0] ed, input logic el);
        vec_t v;
        v = '{r:r, iv:iv, d:d, ordy:ordy, chk:chk, ev:ev, er:er, ed:ed, el:el};
        tbl.push_back(v);
    endfunction

    // One cycle on the LEVEL=4 instance, checked against the scoreboard queue.
    task automatic sb4(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
        logic  ev, er;
        item_t it;
        rst4 = r; iv4 = iv; id4 = d; or4 = ordy;
        #1;
        ev = (q4.size() != 0);
        er = (q4.size() == 0) || (q4.size() == 1 && ordy);
        cmp("sb4_valid", {31'h0, ov4}, {31'h0, ev});
        cmp("sb4_busy", {31'h0, busy4}, {31'h0, ev});
        cmp("sb4_ready", {31'h0, ir4}, {31'h0, er});
        if (ev) begin
            cmp("sb4_data", {24'h0, od4}, {24'h0, q4[0].d});
            cmp("sb4_last", {31'h0, ol4}, {31'h0, q4[0].l});
        end else begin
            cmp("sb4_idle_data", {24'h0, od4}, 32'h0);
            cmp("sb4_idle_last", {31'h0, ol4}, 32'h0);
        end
        @(posedge clk);
        #1;
        if (r) begin
            q4.delete();
        end else begin
            if (ev && ordy) void'(q4.pop_front());
            if (iv && er) begin
                for (int k = 0; k < 4; k++) begin
                    it.d = d[k*8 +: 8];
                    it.l = (k == 3);
                    q4.push_back(it);
                end
            end
        end
    endtask

    // One cycle on the LEVEL=1 instance; fired reports the DUT's own output handshake.
    task automatic sb1(input logic r, input logic iv, input logic [7:0] d, input logic ordy,
                       output logic fired);
        logic ev, er;
        rst1 = r; iv1 = iv; id1 = d; or1 = ordy;
        #1;
        ev = (q1.size() != 0);
        er = (q1.size() == 0) || ordy;
        fired = ov1 & ordy;
        cmp("sb1_valid", {31'h0, ov1}, {31'h0, ev});
        cmp("sb1_ready", {31'h0, ir1}, {31'h0, er});
        if (ev) begin
            cmp("sb1_data", {24'h0, od1}, {24'h0, q1[0]});
            cmp("sb1_last", {31'h0, ol1}, 32'h1);
        end else begin
            cmp("sb1_idle_last", {31'h0, ol1}, 32'h0);
        end
        @(posedge clk);
        #1;
        if (r) begin
            q1.delete();
        end else begin
            if (ev && ordy) void'(q1.pop_front());
            if (iv && er) q1.push_back(d);
        end
    endtask

    initial begin
        logic [31:0] words[2];
        logic        acc;
        logic        fired;
        int          idx;
        int          thr;

        #1;
        // Reset/idle, single word, backpressure with an ignored in_valid while stalled
        add(1'b1, 1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b1, 1'b1, 32'h44332211, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 32'h44332211, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b1, 32'h44332211, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1);
        add(1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1);
        add(1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst4 = tbl[i].r; iv4 = tbl[i].iv; id4 = tbl[i].d; or4 = tbl[i].ordy;
            #1;
            if (tbl[i].chk) begin
                cmp($sformatf("vec%0d_valid", i), {31'h0, ov4}, {31'h0, tbl[i].ev});
                cmp($sformatf("vec%0d_busy", i), {31'h0, busy4}, {31'h0, tbl[i].ev});
                cmp($sformatf("vec%0d_ready", i), {31'h0, ir4}, {31'h0, tbl[i].er});
                cmp($sformatf("vec%0d_data", i), {24'h0, od4}, {24'h0, tbl[i].ed});
                cmp($sformatf("vec%0d_last", i), {31'h0, ol4}, {31'h0, tbl[i].el});
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back words, out_ready held high
        words[0] = 32'h44332211;
        words[1] = 32'h88776655;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 2) begin
                acc = (q4.size() <= 1);
                sb4(1'b0, 1'b1, words[idx], 1'b1);
                if (acc) idx++;
            end else begin
                sb4(1'b0, 1'b0, 32'h0, 1'b1);
            end
        end
        cmp("b2b_words_accepted", idx, 32'd2);

        // Mid-word reset, then a fresh word
        sb4(1'b0, 1'b1, 32'h44332211, 1'b1);
        sb4(1'b0, 1'b0, 32'h0, 1'b1);
        sb4(1'b0, 1'b0, 32'h0, 1'b1);
        sb4(1'b1, 1'b1, 32'h55555555, 1'b1);
        sb4(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
        for (int c = 0; c < 5; c++) sb4(1'b0, 1'b0, 32'h0, 1'b1);

        // LEVEL=1: random traffic, then full-throughput streaming
        rst4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
        sb1(1'b1, 1'b0, 8'h00, 1'b0, fired);
        for (int c = 0; c < 1000; c++) begin
            sb1(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), fired);
        end
        sb1(1'b0, 1'b0, 8'h00, 1'b1, fired);
        sb1(1'b0, 1'b0, 8'h00, 1'b1, fired);
        thr = 0;
        for (int c = 0; c < 20; c++) begin
            sb1(1'b0, 1'b1, 8'(c + 1), 1'b1, fired);
            if (fired) thr++;
        end
        cmp("l1_throughput", thr, 32'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
